// File: rtl/la_eth_pkg.sv
// Shared constants and types for the la_eth GMII transmit/receive paths.
package la_eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
  localparam int unsigned ETH_MIN_PAYLOAD = 60;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StSfd,
    StData,
    StDrop,
    StPad,
    StFcs,
    StIfg
  } tx_state_e;

endpackage

// File: rtl/la_eth_crc32.sv
// Combinational CRC-32 (reflected) advance by one byte, LSB first.
module la_eth_crc32
  import la_eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  // Bit-serial shift unrolled over the eight data bits.
  always_comb begin
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/la_eth_gmii_tx.sv
// GMII transmit framer: preamble, SFD, payload, optional pad, FCS, IFG.
// Optional zero-padding of short frames to 60 payload bytes is enabled by
// defining LA_ETH_TX_PAD_EN.
module la_eth_gmii_tx
  import la_eth_pkg::*;
#(
  parameter string       TARGET = "DEFAULT",
  parameter int unsigned IFG    = 12,
  parameter int unsigned CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic [7:0]    gmii_tx_data,
  output logic          gmii_tx_enable,
  output logic          gmii_tx_error,
  output logic          busy,
  output logic [CW-1:0] frame_count,
  output logic [CW-1:0] underrun_count
);

  // Technology target has no functional effect in this block.
  if (TARGET == "") begin : g_target_unset
  end

  // IFG state lasts IFG-1 cycles; the IDLE cycle that follows completes the
  // gap, so back-to-back frames show exactly IFG idle cycles on the wire.
  localparam logic [7:0] IfgLast = 8'(IFG - 2);

  tx_state_e state_q, state_d;

  logic [2:0]    pre_cnt_q, pre_cnt_d;
  logic [1:0]    fcs_idx_q, fcs_idx_d;
  logic [7:0]    ifg_cnt_q, ifg_cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic [31:0]   crc_next;
  logic [7:0]    crc_data;
  logic [31:0]   fcs_word;
  logic [7:0]    fcs_byte;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] underrun_cnt_q, underrun_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;
  logic          tx_er_q, tx_er_d;
  logic          pad_needed;
  logic          pad_done;

`ifdef LA_ETH_TX_PAD_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        byte_inc;

  // After this byte the count is byte_cnt_q+1; compare against 59 to avoid a wider add.
  assign pad_needed = byte_cnt_q < 16'(ETH_MIN_PAYLOAD - 1);
  assign pad_done   = byte_cnt_q >= 16'(ETH_MIN_PAYLOAD - 1);
  assign byte_inc   = ((state_q == StData) && in_valid) || (state_q == StPad);

  // Payload byte counter, saturating, cleared at SFD.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (state_q == StSfd) begin
      byte_cnt_d = '0;
    end else if (byte_inc && (byte_cnt_q != 16'hFFFF)) begin
      byte_cnt_d = byte_cnt_q + 16'd1;
    end
  end

  // Byte counter register.
  always_ff @(posedge clk) begin
    if (reset) byte_cnt_q <= '0;
    else       byte_cnt_q <= byte_cnt_d;
  end
`else
  assign pad_needed = 1'b0;
  assign pad_done   = 1'b1;
`endif

  assign crc_data = (state_q == StPad) ? 8'h00 : in_data;
  assign fcs_word = ~crc_q;
  assign fcs_byte = fcs_word[8*fcs_idx_q +: 8];

  la_eth_crc32 u_crc (
    .crc      (crc_q),
    .data     (crc_data),
    .crc_next (crc_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StPre;
      StPre:  if (pre_cnt_q == 3'd6) state_d = StSfd;
      StSfd:  state_d = StData;
      StData: begin
        if (!in_valid)    state_d = StDrop;
        else if (in_last) state_d = pad_needed ? StPad : StFcs;
      end
      StDrop: if (in_valid && in_last) state_d = StIfg;
      StPad:  if (pad_done) state_d = StFcs;
      StFcs:  if (fcs_idx_q == 2'd3) state_d = StIfg;
      StIfg:  if (ifg_cnt_q == IfgLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next GMII pin values, chosen by the current state.
  always_comb begin
    tx_data_d = 8'h00;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    unique case (state_q)
      StPre: begin
        tx_data_d = ETH_PREAMBLE;
        tx_en_d   = 1'b1;
      end
      StSfd: begin
        tx_data_d = ETH_SFD;
        tx_en_d   = 1'b1;
      end
      StData: begin
        tx_en_d = 1'b1;
        if (in_valid) tx_data_d = in_data;
        else          tx_er_d   = 1'b1;
      end
      StPad: tx_en_d = 1'b1;
      StFcs: begin
        tx_data_d = fcs_byte;
        tx_en_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: phase counters, CRC and statistics.
  always_comb begin
    pre_cnt_d      = (state_q == StPre) ? pre_cnt_q + 3'd1 : 3'd0;
    fcs_idx_d      = (state_q == StFcs) ? fcs_idx_q + 2'd1 : 2'd0;
    ifg_cnt_d      = (state_q == StIfg) ? ifg_cnt_q + 8'd1 : 8'd0;
    crc_d          = crc_q;
    frame_cnt_d    = frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    if (state_q == StSfd) begin
      crc_d = ETH_CRC_INIT;
    end else if (((state_q == StData) && in_valid) || (state_q == StPad)) begin
      crc_d = crc_next;
    end
    if ((state_q == StFcs) && (fcs_idx_q == 2'd3)) begin
      frame_cnt_d = frame_cnt_q + CW'(1);
    end
    if ((state_q == StData) && !in_valid) begin
      underrun_cnt_d = underrun_cnt_q + CW'(1);
    end
  end

  // Datapath and pin registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q      <= '0;
      fcs_idx_q      <= '0;
      ifg_cnt_q      <= '0;
      crc_q          <= ETH_CRC_INIT;
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
      tx_data_q      <= 8'h00;
      tx_en_q        <= 1'b0;
      tx_er_q        <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      fcs_idx_q      <= fcs_idx_d;
      ifg_cnt_q      <= ifg_cnt_d;
      crc_q          <= crc_d;
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
      tx_data_q      <= tx_data_d;
      tx_en_q        <= tx_en_d;
      tx_er_q        <= tx_er_d;
    end
  end

  assign in_ready       = (state_q == StData) || (state_q == StDrop);
  assign busy           = (state_q != StIdle);
  assign gmii_tx_data   = tx_data_q;
  assign gmii_tx_enable = tx_en_q;
  assign gmii_tx_error  = tx_er_q;
  assign frame_count    = frame_cnt_q;
  assign underrun_count = underrun_cnt_q;

endmodule

// File: tb/tb_la_eth_gmii_tx.sv
// Scoreboard bench for la_eth_gmii_tx: expected pin bytes are queued when a
// frame is issued and popped by a monitor whenever TX_EN or TX_ER is high.
module tb_la_eth_gmii_tx;

`ifdef LA_ETH_TX_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] data;
    logic       er;
  } pin_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  gmii_tx_data;
  logic        gmii_tx_enable;
  logic        gmii_tx_error;
  logic        busy;
  logic [15:0] frame_count;
  logic [15:0] underrun_count;

  la_eth_gmii_tx #(
    .TARGET ("DEFAULT"),
    .IFG    (12),
    .CW     (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .gmii_tx_data   (gmii_tx_data),
    .gmii_tx_enable (gmii_tx_enable),
    .gmii_tx_error  (gmii_tx_error),
    .busy           (busy),
    .frame_count    (frame_count),
    .underrun_count (underrun_count)
  );

  always #4 clk = ~clk;

  pin_t       exp_q[$];
  logic [7:0] cap_q[$];
  pin_t       mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int run_len = 0, last_run = 0, gap_len = 0, last_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic bq_t ramp(input int n, input int start);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(8'(start + k));
    return q;
  endfunction

  // Monitor: pops an expected pin byte for every active cycle, tracks run/gap lengths.
  always @(negedge clk) begin
    if (gmii_tx_enable || gmii_tx_error) begin
      cap_q.push_back(gmii_tx_data);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected pin byte: got 0x%0h er=%0b, want nothing", gmii_tx_data,
                 gmii_tx_error);
      end else begin
        mon_e = exp_q.pop_front();
        check("pin data", {24'h0, gmii_tx_data}, {24'h0, mon_e.data});
        check("pin error", {31'h0, gmii_tx_error}, {31'h0, mon_e.er});
      end
    end
    if (gmii_tx_enable) begin
      if (run_len == 0) last_gap = gap_len;
      gap_len = 0;
      run_len++;
    end else begin
      if (run_len > 0) last_run = run_len;
      run_len = 0;
      gap_len++;
    end
  end

  // Queue preamble, SFD, payload, pad and FCS; returns the expected enable run length.
  task automatic push_frame(input bq_t p, output int len);
    logic [31:0] c;
    bq_t body;
    body = p;
    if (PadEn) while (body.size() < 60) body.push_back(8'h00);
    for (int k = 0; k < 7; k++) exp_q.push_back('{data: 8'h55, er: 1'b0});
    exp_q.push_back('{data: 8'hD5, er: 1'b0});
    c = 32'hFFFFFFFF;
    foreach (body[k]) begin
      exp_q.push_back('{data: body[k], er: 1'b0});
      c = crc_byte(c, body[k]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back('{data: c[8*k +: 8], er: 1'b0});
    len = 8 + body.size() + 4;
  endtask

  // Drive bytes until all sent or stop_at accepted; in_valid is left as-is on return.
  task automatic drive(input bq_t p, input int stop_at, output int sent);
    int  i = 0;
    int  budget = 300;
    logic acc;
    while (i < p.size() && i != stop_at) begin
      in_valid = 1'b1;
      in_data  = p[i];
      in_last  = (i == p.size() - 1);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        budget = 300;
      end else if (--budget == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drive timeout: got %0d bytes accepted, want %0d", i, p.size());
        break;
      end
    end
    sent = i;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    if (k == 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait idle timeout: got busy=1, want busy=0");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_q.delete();
    cap_q.delete();
    run_len = 0;
    gap_len = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    flush();
  endtask

  task automatic check_residue(input string name, input int len);
    logic [31:0] c;
    check({name, " length"}, cap_q.size(), len);
    c = 32'hFFFFFFFF;
    for (int k = 8; k < cap_q.size(); k++) c = crc_byte(c, cap_q[k]);
    check({name, " residue"}, c, 32'hDEBB20E3);
    check({name, " queue drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t p, p2;
    int  len, len2, sent;

    // Reset and idle outputs.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle outputs", {gmii_tx_data, gmii_tx_enable, gmii_tx_error, in_ready, busy},
            32'h0);
      check("idle counters", {frame_count, underrun_count}, 32'h0);
    end

    // 60-byte ramp payload, no stalls.
    cap_q.delete();
    p = ramp(60, 0);
    push_frame(p, len);
    drive(p, -1, sent);
    in_valid = 1'b0;
    wait_idle();
    check("ramp60 enable run", last_run, 72);
    check("ramp60 frame_count", frame_count, 1);
    check_residue("ramp60", len);

    // 1-byte payload.
    cap_q.delete();
    p = {8'hAA};
    push_frame(p, len);
    drive(p, -1, sent);
    in_valid = 1'b0;
    wait_idle();
    check("one-byte enable run", last_run, PadEn ? 72 : 13);
    check("one-byte frame_count", frame_count, 2);
    check_residue("one-byte", len);

    // Back-to-back frames with in_valid held high.
    p  = ramp(20, 8'h40);
    p2 = ramp(20, 8'h80);
    push_frame(p, len);
    push_frame(p2, len2);
    drive(p, -1, sent);
    cap_q.delete();
    drive(p2, -1, sent);
    in_valid = 1'b0;
    wait_idle();
    check("b2b inter-frame gap", last_gap, 12);
    check("b2b second run", last_run, len2);
    check("b2b frame_count", frame_count, 4);
    check("b2b queue drained", exp_q.size(), 0);

    // Underrun after byte 10 of 40.
    do_reset();
    p = ramp(40, 8'h10);
    for (int k = 0; k < 7; k++) exp_q.push_back('{data: 8'h55, er: 1'b0});
    exp_q.push_back('{data: 8'hD5, er: 1'b0});
    for (int k = 0; k < 10; k++) exp_q.push_back('{data: p[k], er: 1'b0});
    exp_q.push_back('{data: 8'h00, er: 1'b1});
    drive(p, 10, sent);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    p2 = p[10:$];
    drive(p2, -1, sent);
    in_valid = 1'b0;
    wait_idle();
    check("underrun enable run", last_run, 19);
    check("underrun underrun_count", underrun_count, 1);
    check("underrun frame_count", frame_count, 0);
    check("underrun queue drained", exp_q.size(), 0);

    // Good frame, then reset in the DATA phase of the next one.
    p = ramp(16, 8'hC0);
    push_frame(p, len);
    drive(p, -1, sent);
    in_valid = 1'b0;
    wait_idle();
    check("pre-reset frame_count", frame_count, 1);
    p = ramp(20, 8'hE0);
    push_frame(p, len);
    drive(p, 5, sent);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset enable drop", {gmii_tx_enable, gmii_tx_error}, 0);
    check("reset counters", {frame_count, underrun_count}, 0);
    check("reset busy", busy, 0);
    flush();

    // Following frame must be clean.
    p = ramp(30, 8'h33);
    push_frame(p, len);
    drive(p, -1, sent);
    in_valid = 1'b0;
    wait_idle();
    check("post-reset enable run", last_run, len);
    check("post-reset frame_count", frame_count, 1);
    check_residue("post-reset", len);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
